// File: rtl/fetch_prefetch_buffer.sv
// Prefetch/align unit: keeps word reads in flight, buffers halfwords and
// presents aligned 16/32-bit instructions to decode with valid/ready.
module fetch_prefetch_buffer #(
  parameter int unsigned DEPTH_WORDS     = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic                  out_compressed
);

  localparam int unsigned HW_DEPTH = 2 * DEPTH_WORDS;
  localparam int unsigned PTR_W    = $clog2(HW_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned OUT_W    = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned REQ_W    = CNT_W + OUT_W + 2;

  logic [15:0]           fifo_q [HW_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      hw_count_q, hw_count_d;
  logic [OUT_W-1:0]      outstanding_q, outstanding_d, discard_q, discard_d;
  logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d, head_pc_q, head_pc_d;
  logic                  skip_low_q, skip_low_d;

  logic [15:0]      h0, h1;
  logic             is_comp, avail, pop, rsp_accept, gnt_fire, fits;
  logic [CNT_W-1:0] pop_n, push_n, hw_count_next;
  logic [REQ_W-1:0] req_need;

  assign h0      = fifo_q[rd_ptr_q];
  assign h1      = fifo_q[rd_ptr_q + PTR_W'(1)];
  assign is_comp = (h0[1:0] != 2'b11);
  assign avail   = is_comp ? (hw_count_q >= CNT_W'(1)) : (hw_count_q >= CNT_W'(2));

  assign out_valid      = !redirect_valid && avail;
  assign out_instr      = !out_valid ? 32'h0 : (is_comp ? {16'h0, h0} : {h1, h0});
  assign out_compressed = out_valid && is_comp;
  assign out_pc         = head_pc_q;

  assign pop    = out_valid && out_ready;
  assign pop_n  = !pop ? CNT_W'(0) : (is_comp ? CNT_W'(1) : CNT_W'(2));

  // Responses arriving during a redirect or owed to an earlier stream are dropped.
  assign rsp_accept = mem_rvalid && !redirect_valid && (discard_q == '0);
  assign push_n     = !rsp_accept ? CNT_W'(0) : (skip_low_q ? CNT_W'(1) : CNT_W'(2));

  assign hw_count_next = hw_count_q + push_n - pop_n;

  // Reserve room for every read in flight plus the one about to be issued.
  assign req_need = REQ_W'(hw_count_next) + ((REQ_W'(outstanding_q) + REQ_W'(1)) << 1);
  assign fits     = (req_need <= REQ_W'(HW_DEPTH));

  assign mem_req  = rst_n && !redirect_valid
                    && (outstanding_q < OUT_W'(MAX_OUTSTANDING)) && fits;
  assign mem_addr = fetch_addr_q;
  assign gnt_fire = mem_req && mem_gnt;

  always_comb begin
    outstanding_d = outstanding_q + OUT_W'(gnt_fire) - OUT_W'(mem_rvalid);
    discard_d     = discard_q;
    if (mem_rvalid && (discard_q != '0)) begin
      discard_d = discard_q - OUT_W'(1);
    end
    fetch_addr_d = gnt_fire ? fetch_addr_q + ADDR_WIDTH'(4) : fetch_addr_q;
    skip_low_d   = rsp_accept ? 1'b0 : skip_low_q;
    head_pc_d    = head_pc_q;
    if (pop) begin
      head_pc_d = head_pc_q + (is_comp ? ADDR_WIDTH'(2) : ADDR_WIDTH'(4));
    end
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop_n);
    wr_ptr_d   = wr_ptr_q + PTR_W'(push_n);
    hw_count_d = hw_count_next;

    if (redirect_valid) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      hw_count_d   = '0;
      head_pc_d    = {redirect_pc[ADDR_WIDTH-1:1], 1'b0};
      fetch_addr_d = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      skip_low_d   = redirect_pc[1];
      discard_d    = outstanding_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      hw_count_q    <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      fetch_addr_q  <= {RESET_PC[ADDR_WIDTH-1:2], 2'b00};
      skip_low_q    <= RESET_PC[1];
      head_pc_q     <= RESET_PC;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      hw_count_q    <= hw_count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      fetch_addr_q  <= fetch_addr_d;
      skip_low_q    <= skip_low_d;
      head_pc_q     <= head_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rsp_accept) begin
      if (skip_low_q) begin
        fifo_q[wr_ptr_q] <= mem_rdata[31:16];
      end else begin
        fifo_q[wr_ptr_q]              <= mem_rdata[15:0];
        fifo_q[wr_ptr_q + PTR_W'(1)]  <= mem_rdata[31:16];
      end
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (int'(hw_count_q) + int'(push_n) - int'(pop_n)) <= int'(HW_DEPTH));

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Directed bench for fetch_prefetch_buffer with an in-order, fixed-latency
// memory responder.
module tb_fetch_prefetch_buffer;
  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt = 1'b1;
  logic          mem_rvalid;
  logic [31:0]   mem_rdata;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_pc;
  logic          out_compressed;

  int checks = 0;
  int passed = 0;

  logic [31:0]   mem [128];
  int            lat = 1;
  int            cyc;
  int            gnt_count;
  logic [AW-1:0] pend_addr [$];
  int            pend_due [$];
  logic [AW-1:0] rsp_a;

  always #5 clk = ~clk;

  fetch_prefetch_buffer #(
    .DEPTH_WORDS(4), .MAX_OUTSTANDING(2), .ADDR_WIDTH(AW), .RESET_PC('0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_compressed(out_compressed)
  );

  // Memory: each grant answered 'lat' cycles later, in order, one per cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_addr.delete();
      pend_due.delete();
      mem_rvalid <= 1'b0;
      mem_rdata  <= '0;
      cyc        <= 0;
      gnt_count  <= 0;
    end else begin
      cyc <= cyc + 1;
      if (mem_req && mem_gnt) begin
        pend_addr.push_back(mem_addr);
        pend_due.push_back(cyc + lat);
        gnt_count <= gnt_count + 1;
      end
      if (pend_due.size() > 0 && pend_due[0] <= cyc + 1) begin
        rsp_a = pend_addr.pop_front();
        void'(pend_due.pop_front());
        mem_rvalid <= 1'b1;
        mem_rdata  <= mem[rsp_a[8:2]];
      end else begin
        mem_rvalid <= 1'b0;
      end
    end
  end

  task automatic mem_fill();
    for (int i = 0; i < 128; i++) mem[i] = 32'h0000_0013;
  endtask

  task automatic do_redirect(input logic [AW-1:0] pc);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    #1;
    checks++;
    if (out_valid !== 1'b0 || mem_req !== 1'b0)
      $display("FAIL redirect_quiet: got valid=%b req=%b want 0 0", out_valid, mem_req);
    else passed++;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_req, out_valid, out_compressed} !== 3'b000)
      $display("FAIL reset_ctrl: got req/valid/c=%b%b%b want 000", mem_req, out_valid, out_compressed);
    else passed++;
    checks++;
    if (out_instr !== 32'h0) $display("FAIL reset_instr: got %h want 0", out_instr);
    else passed++;
    checks++;
    if (out_pc !== '0) $display("FAIL reset_pc: got %h want 0", out_pc);
    else passed++;
    rst_n = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== '0)
      $display("FAIL reset_first_req: got req=%b addr=%h want 1 0", mem_req, mem_addr);
    else passed++;
  endtask

  task automatic test_steady();
    int n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 20);
    checks++;
    if (n !== 2) $display("FAIL fill_latency: got %0d want 2 cycles", n);
    else passed++;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== AW'(4 * i) || out_instr !== 32'h13
          || out_compressed !== 1'b0)
        $display("FAIL steady[%0d]: got v=%b pc=%h i=%h c=%b want 1 %h 00000013 0",
                 i, out_valid, out_pc, out_instr, out_compressed, 4 * i);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_compressed();
    logic [AW-1:0] e_pc [3];
    logic [31:0]   e_in [3];
    logic          e_c  [3];
    mem_fill();
    mem[0] = 32'h4501_4501;
    mem[1] = 32'h00A0_0093;
    e_pc[0] = 'h0; e_in[0] = 32'h0000_4501; e_c[0] = 1'b1;
    e_pc[1] = 'h2; e_in[1] = 32'h0000_4501; e_c[1] = 1'b1;
    e_pc[2] = 'h4; e_in[2] = 32'h00A0_0093; e_c[2] = 1'b0;
    do_redirect('0);
    for (int i = 0; i < 3; i++) begin
      int n = 0;
      while (!out_valid && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (out_valid !== 1'b1 || out_pc !== e_pc[i] || out_instr !== e_in[i]
          || out_compressed !== e_c[i])
        $display("FAIL compressed[%0d]: got v=%b pc=%h i=%h c=%b want 1 %h %h %b",
                 i, out_valid, out_pc, out_instr, out_compressed, e_pc[i], e_in[i], e_c[i]);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_straddle();
    logic [AW-1:0] e_pc [4];
    logic [31:0]   e_in [4];
    logic          e_c  [4];
    mem_fill();
    mem[0] = 32'h0013_4505;
    mem[1] = 32'h0000_0013;
    e_pc[0] = 'h0; e_in[0] = 32'h0000_4505; e_c[0] = 1'b1;
    e_pc[1] = 'h2; e_in[1] = 32'h0013_0013; e_c[1] = 1'b0;
    e_pc[2] = 'h6; e_in[2] = 32'h0000_0000; e_c[2] = 1'b1;
    e_pc[3] = 'h8; e_in[3] = 32'h0000_0013; e_c[3] = 1'b0;
    do_redirect('0);
    for (int i = 0; i < 4; i++) begin
      int n = 0;
      while (!out_valid && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (out_valid !== 1'b1 || out_pc !== e_pc[i] || out_instr !== e_in[i]
          || out_compressed !== e_c[i])
        $display("FAIL straddle[%0d]: got v=%b pc=%h i=%h c=%b want 1 %h %h %b",
                 i, out_valid, out_pc, out_instr, out_compressed, e_pc[i], e_in[i], e_c[i]);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    int g0;
    mem_fill();
    out_ready = 1'b0;
    do_redirect('0);
    g0 = gnt_count;
    repeat (20) @(negedge clk);
    checks++;
    if (gnt_count - g0 !== 4) $display("FAIL stall_grants: got %0d want 4", gnt_count - g0);
    else passed++;
    checks++;
    if (mem_req !== 1'b0 || out_valid !== 1'b1 || out_pc !== '0)
      $display("FAIL stall_hold: got req=%b v=%b pc=%h want 0 1 0", mem_req, out_valid, out_pc);
    else passed++;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      int n = 0;
      while (!out_valid && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (out_valid !== 1'b1 || out_pc !== AW'(4 * i) || out_instr !== 32'h13)
        $display("FAIL stall_drain[%0d]: got v=%b pc=%h i=%h want 1 %h 00000013",
                 i, out_valid, out_pc, out_instr, 4 * i);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_redirect();
    logic [AW-1:0] e_pc [3];
    logic [31:0]   e_in [3];
    logic          e_c  [3];
    int n = 0;
    lat = 2;
    mem_fill();
    mem[7'h40] = 32'hABCD_1234;
    e_pc[0] = 'h102; e_in[0] = 32'h0000_ABCD; e_c[0] = 1'b1;
    e_pc[1] = 'h104; e_in[1] = 32'h0000_0013; e_c[1] = 1'b0;
    e_pc[2] = 'h108; e_in[2] = 32'h0000_0013; e_c[2] = 1'b0;
    do_redirect('0);
    while ((pend_addr.size() + int'(mem_rvalid)) != 2 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (pend_addr.size() + int'(mem_rvalid) !== 2)
      $display("FAIL redir_inflight: got %0d want 2", pend_addr.size() + int'(mem_rvalid));
    else passed++;
    do_redirect(32'h102);
    n = 0;
    while (!mem_req && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100)
      $display("FAIL redir_addr: got req=%b addr=%h want 1 00000100", mem_req, mem_addr);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (!out_valid && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (out_valid !== 1'b1 || out_pc !== e_pc[i] || out_instr !== e_in[i]
          || out_compressed !== e_c[i])
        $display("FAIL redirect[%0d]: got v=%b pc=%h i=%h c=%b want 1 %h %h %b",
                 i, out_valid, out_pc, out_instr, out_compressed, e_pc[i], e_in[i], e_c[i]);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    lat = 2;
    mem_fill();
    do_redirect(32'h40);
    while (!mem_rvalid && n < 20) begin @(negedge clk); n++; end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, out_valid, out_compressed} !== 3'b000 || out_instr !== 32'h0 || out_pc !== '0)
      $display("FAIL midreset_outs: got req/v/c=%b%b%b i=%h pc=%h want 000 0 0",
               mem_req, out_valid, out_compressed, out_instr, out_pc);
    else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== '0)
      $display("FAIL midreset_req: got req=%b addr=%h want 1 0", mem_req, mem_addr);
    else passed++;
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (out_valid !== 1'b1 || out_pc !== '0 || out_instr !== 32'h13)
      $display("FAIL midreset_first: got v=%b pc=%h i=%h want 1 0 00000013",
               out_valid, out_pc, out_instr);
    else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    mem_fill();
    test_reset();
    test_steady();
    test_compressed();
    test_straddle();
    test_stall();
    test_redirect();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
